// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
//   Word-organised synchronous data memory behind the memory controller.
//   A request (AddressBusSel=1) is captured in IDLE, waits WAIT_STATES
//   cycles, then performs the LDR read or STR write in ACCESS and pulses Done.
//
// Parameters
//   DEPTH_LOG2  : array holds 2**DEPTH_LOG2 32-bit words
//   WAIT_STATES : extra cycles between capture and array access (0..15)
//
// Ports
//   Clk           in   rising-edge clock
//   Reset         in   synchronous, active-high reset
//   AddressBusSel in   request valid
//   RW            in   1 = read (LDR), 0 = write (STR)
//   AddressBus    in   32-bit byte address
//   DataBus       in   32-bit write data
//   ReadData      out  registered load result (holds last read)
//   Busy          out  access in flight, request inputs ignored
//   Done          out  one-cycle completion pulse
//   Fault         out  misalignment pulse (tied 0 unless MISALIGN_TRAP_EN)
//
// Build option
//   MISALIGN_TRAP_EN : when defined, addr[1:0] != 0 suppresses the access
//                      and raises Fault alongside Done.
// ---------------------------------------------------------------------------
module data_mem_unit #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        AddressBusSel,
    input  logic        RW,
    input  logic [31:0] AddressBus,
    input  logic [31:0] DataBus,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_data;
    logic                  lat_rw;
    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oor;
    logic                  mis;
    logic                  capture;

    assign idx     = lat_addr[DEPTH_LOG2+1:2];
    assign oor     = (lat_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign Busy    = (state != S_IDLE);
    // Not capturing in the Done cycle keeps a held AddressBusSel from
    // re-issuing the request that just completed.
    assign capture = (state == S_IDLE) && AddressBusSel && !Done;

`ifdef MISALIGN_TRAP_EN
    assign mis = (lat_addr[1:0] != 2'b00);

    always_ff @(posedge Clk) begin
        if (Reset)
            Fault <= 1'b0;
        else
            Fault <= (state == S_ACCESS) && mis;
    end
`else
    logic unused_lsb;
    assign mis        = 1'b0;
    assign unused_lsb = ^lat_addr[1:0];
    assign Fault      = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            ReadData <= 32'd0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        lat_addr <= AddressBus;
                        lat_data <= DataBus;
                        lat_rw   <= RW;
                        if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= S_ACCESS;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                S_ACCESS: begin
                    state <= S_IDLE;
                    Done  <= 1'b1;
                    // Misaligned reads leave ReadData untouched; out-of-range
                    // reads return zero.
                    if (lat_rw && !mis)
                        ReadData <= oor ? 32'd0 : mem[idx];
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; the write is gated by Reset so an access abandoned
    // in ACCESS never lands.
    always_ff @(posedge Clk) begin
        if (!Reset && state == S_ACCESS && !lat_rw && !oor && !mis)
            mem[idx] <= lat_data;
    end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

    localparam int DL = 8;
    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        AddressBusSel;
    logic        RW;
    logic [31:0] AddressBus;
    logic [31:0] DataBus;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        Fault;

    always #5 Clk = ~Clk;

    data_mem_unit #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .AddressBusSel(AddressBusSel),
        .RW           (RW),
        .AddressBus   (AddressBus),
        .DataBus      (DataBus),
        .ReadData     (ReadData),
        .Busy         (Busy),
        .Done         (Done),
        .Fault        (Fault)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          known;
        bit          fault;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mdl[int];
    logic [31:0] last_rd;
    bit          last_known;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: word-addressed array plus the last load result.
    function automatic exp_t model(bit rw, logic [31:0] addr, logic [31:0] data);
        exp_t e;
        int   idx;
        bit   oor;
        bit   mis;
        idx = int'((addr >> 2) % (1 << DL));
        oor = (addr >= (32'd1 << (DL + 2)));
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (addr % 4) != 0;
`endif
        if (!mis) begin
            if (rw) begin
                if (oor) begin
                    last_rd = 32'd0; last_known = 1'b1;
                end else if (mdl.exists(idx)) begin
                    last_rd = mdl[idx]; last_known = 1'b1;
                end else begin
                    last_known = 1'b0;
                end
            end else if (!oor) begin
                mdl[idx] = data;
            end
        end
        e.rdata = last_rd;
        e.known = last_known;
        e.fault = mis;
        return e;
    endfunction

    // Monitor: every Done pops one expectation.
    always @(negedge Clk) begin
        if (Reset !== 1'b1) begin
            if (Done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: Done=1 with no request outstanding at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.known) check("rdata", ReadData, mon_e.rdata);
                    check("fault_on_done", Fault, mon_e.fault);
                end
            end else begin
                check("fault_idle", Fault, 0);
            end
        end
    end

    task automatic req(input bit rw, input logic [31:0] addr, input logic [31:0] data, input bit hold);
        int   bc;
        exp_t e;
        @(negedge Clk);
        AddressBusSel = 1'b1;
        RW            = rw;
        AddressBus    = addr;
        DataBus       = data;
        e = model(rw, addr, data);
        sb.push_back(e);
        @(negedge Clk);
        if (hold) begin
            AddressBus = addr + 32'd4;
            DataBus    = 32'h5555_5555;
        end else begin
            AddressBusSel = 1'b0;
        end
        bc = 0;
        while (Busy === 1'b1 && bc < 40) begin
            bc++;
            @(negedge Clk);
        end
        check("busy_cycles", bc, WS + 1);
        check("done_latency", Done, 1);
        @(negedge Clk);
        if (hold) check("no_reissue", Busy, 0);
        AddressBusSel = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; AddressBusSel = 1'b0; RW = 1'b0;
        AddressBus = 32'd0; DataBus = 32'd0;
        last_rd = 32'd0; last_known = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_readdata", ReadData, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_fault", Fault, 0);
        Reset = 1'b0;

        // write, read-back, neighbour read
        req(1'b0, 32'h0000_0010, 32'h9abc_def0, 1'b0);
        req(1'b1, 32'h0000_0010, 32'h0, 1'b0);
        req(1'b1, 32'h0000_0014, 32'h0, 1'b0);
        req(1'b1, 32'h0000_0010, 32'h0, 1'b0);

        // fill the rest of the array with known data
        for (int i = 0; i < (1 << DL); i++) begin
            if (i != 4 && i != 5)
                req(1'b0, 32'(i) << 2, (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0000, 1'b0);
        end

        // out of range
        req(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        req(1'b1, 32'h1234_5678, 32'h0, 1'b0);
        req(1'b1, 32'h0000_0010, 32'h0, 1'b0);

        // inputs ignored while busy, held select
        req(1'b0, 32'h0000_0020, 32'hAAAA_AAAA, 1'b1);
        req(1'b1, 32'h0000_0020, 32'h0, 1'b0);
        req(1'b1, 32'h0000_0024, 32'h0, 1'b0);

        // reset mid-write
        @(negedge Clk);
        AddressBusSel = 1'b1; RW = 1'b0;
        AddressBus = 32'h0000_0010; DataBus = 32'hDEAD_BEEF;
        @(negedge Clk);
        AddressBusSel = 1'b0;
        check("busy_before_reset", Busy, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_readdata", ReadData, 0);
        last_rd = 32'd0; last_known = 1'b1;
        @(negedge Clk);
        check("abort_no_late_done", Done, 0);
        req(1'b1, 32'h0000_0010, 32'h0, 1'b0);

        // misaligned read
        req(1'b1, 32'h0000_0020, 32'h0, 1'b0);
        req(1'b1, 32'h0000_0011, 32'h0, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            if (k < 7) a = 32'($urandom_range(0, (1 << DL) - 1)) << 2;
            else if (k < 8) a = $urandom | 32'h8000_0000;
            else a = (32'($urandom_range(0, (1 << DL) - 1)) << 2) | 32'($urandom_range(1, 3));
            req(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
        end

        repeat (10) @(negedge Clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
